// File: rtl/iagu_sort.sv
// Sort-path input address generator: streams a contiguous read burst into the IO buffer
// and flags each word to the NPE sorter RD_LAT cycles later. Option: IAGU_SORT_RESTART_EN.
module iagu_sort #(
    parameter int ADDR_W  = 12,
    parameter int PIECE_W = 8,
    parameter int RD_LAT  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_calculate,
    input  logic [ADDR_W-1:0] addr_start_d,
    input  logic [PIECE_W-1:0] in_piece,
    output logic [ADDR_W-1:0] o_d_addr,
    output logic              o_rd_en,
    output logic              o_sorter_out
);
    localparam int DW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  next_addr_q, next_addr_d;
    logic [PIECE_W-1:0] remain_q, remain_d;
    logic [DW-1:0]      drain_q, drain_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               rd_en_q, rd_en_d;
    logic [RD_LAT-1:0]  vld_pipe_q, vld_pipe_d;
    logic               idle_like, take;

    // The final DRAIN cycle behaves like IDLE so back-to-back bursts are accepted.
    assign idle_like = (state_q == IDLE) || ((state_q == DRAIN) && (drain_q == '0));
`ifdef IAGU_SORT_RESTART_EN
    assign take = start_calculate;
`else
    assign take = start_calculate && idle_like;
`endif

    always_comb begin
        state_d     = state_q;
        next_addr_d = next_addr_q;
        remain_d    = remain_q;
        drain_d     = drain_q;
        addr_d      = addr_q;
        rd_en_d     = 1'b0;

        case (state_q)
            READ: begin
                rd_en_d     = 1'b1;
                addr_d      = next_addr_q;
                next_addr_d = next_addr_q + ADDR_W'(1);
                remain_d    = remain_q - PIECE_W'(1);
                if (remain_q == PIECE_W'(1)) begin
                    state_d = DRAIN;
                    drain_d = DW'(RD_LAT - 1);
                end
            end
            DRAIN: begin
                if (drain_q == '0) state_d = IDLE;
                else               drain_d = drain_q - DW'(1);
            end
            default: ;
        endcase

        // A taken start suppresses any read this edge; the address output holds.
        if (take) begin
            rd_en_d     = 1'b0;
            addr_d      = addr_q;
            next_addr_d = addr_start_d;
            remain_d    = in_piece;
            drain_d     = '0;
            state_d     = (in_piece != '0) ? READ : IDLE;
        end

        vld_pipe_d[0] = rd_en_q;
        for (int i = 1; i < RD_LAT; i++) vld_pipe_d[i] = vld_pipe_q[i-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            next_addr_q <= '0;
            remain_q    <= '0;
            drain_q     <= '0;
            addr_q      <= '0;
            rd_en_q     <= 1'b0;
            vld_pipe_q  <= '0;
        end else begin
            state_q     <= state_d;
            next_addr_q <= next_addr_d;
            remain_q    <= remain_d;
            drain_q     <= drain_d;
            addr_q      <= addr_d;
            rd_en_q     <= rd_en_d;
            vld_pipe_q  <= vld_pipe_d;
        end
    end

    assign o_d_addr     = addr_q;
    assign o_rd_en      = rd_en_q;
    assign o_sorter_out = vld_pipe_q[RD_LAT-1];
endmodule

// File: tb/tb_iagu_sort.sv
// Randomized bench for iagu_sort against a queue-based burst model.
module tb_iagu_sort;
    localparam int ADDR_W = 12;
    localparam int PIECE_W = 8;
    localparam int LAT = 1;
`ifdef IAGU_SORT_RESTART_EN
    localparam bit RESTART = 1'b1;
`else
    localparam bit RESTART = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start_calculate = 1'b0;
    logic [ADDR_W-1:0] addr_start_d = '0;
    logic [PIECE_W-1:0] in_piece = '0;
    logic [ADDR_W-1:0] o_d_addr;
    logic o_rd_en, o_sorter_out;

    iagu_sort #(.ADDR_W(ADDR_W), .PIECE_W(PIECE_W), .RD_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .start_calculate(start_calculate),
        .addr_start_d(addr_start_d), .in_piece(in_piece),
        .o_d_addr(o_d_addr), .o_rd_en(o_rd_en), .o_sorter_out(o_sorter_out)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: pending read addresses plus a drain countdown after the last read.
    int pend[$];
    int drain_left = 0;
    bit hist[LAT];
    bit exp_rd = 0;
    bit exp_so = 0;
    int exp_addr = 0;
    int rd_seen = 0;

    task automatic model_step();
        bit idle_like, take, new_rd;
        if (rst) begin
            pend.delete();
            drain_left = 0;
            for (int i = 0; i < LAT; i++) hist[i] = 0;
            exp_rd = 0; exp_so = 0; exp_addr = 0;
        end else begin
            idle_like = (pend.size() == 0) && (drain_left <= 1);
            take = start_calculate && (RESTART || idle_like);
            new_rd = 0;
            if (take) begin
                pend.delete();
                drain_left = 0;
                for (int i = 0; i < int'(in_piece); i++)
                    pend.push_back((int'(addr_start_d) + i) % (1 << ADDR_W));
            end else if (pend.size() > 0) begin
                new_rd = 1;
                exp_addr = pend.pop_front();
                if (pend.size() == 0) drain_left = LAT;
            end else if (drain_left > 0) begin
                drain_left--;
            end
            for (int i = LAT - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = exp_rd;
            exp_so = hist[LAT-1];
            exp_rd = new_rd;
        end
    endtask

    task automatic cyc(input bit r, input bit s, input int a, input int n);
        rst = r;
        start_calculate = s;
        addr_start_d = ADDR_W'(a);
        in_piece = PIECE_W'(n);
        @(posedge clk);
        model_step();
        #1;
        chk("rd_en", 32'(o_rd_en), 32'(exp_rd));
        chk("addr", 32'(o_d_addr), 32'(exp_addr));
        chk("sorter", 32'(o_sorter_out), 32'(exp_so));
        if (o_rd_en === 1'b1) rd_seen++;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(0, 0, $urandom_range(4095), $urandom_range(255));
    endtask

    initial begin
        // Reset held with start pulses present.
        cyc(1, 1, 5, 7);
        cyc(1, 1, 5, 7);
        cyc(1, 1, 5, 7);
        chk("rst_rd_en", 32'(o_rd_en), 32'd0);
        chk("rst_addr", 32'(o_d_addr), 32'd0);
        chk("rst_sorter", 32'(o_sorter_out), 32'd0);

        // Base burst.
        rd_seen = 0;
        cyc(0, 1, 0, 32);
        idle(40);
        chk("base_count", 32'(rd_seen), 32'd32);

        // Zero length.
        rd_seen = 0;
        cyc(0, 1, 12, 0);
        idle(6);
        chk("zero_count", 32'(rd_seen), 32'd0);

        // Wrap at top of address space.
        cyc(0, 1, 'hFFE, 4);
        cyc(0, 0, 0, 0);
        chk("wrap0", 32'(o_d_addr), 32'hFFE);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("wrap2", 32'(o_d_addr), 32'h000);
        idle(5);

        // Start during the 10th read.
        rd_seen = 0;
        cyc(0, 1, 0, 32);
        idle(10);
        cyc(0, 1, 'h100, 8);
        idle(40);
        chk("busy_count", 32'(rd_seen), RESTART ? 32'd18 : 32'd32);

        // Reset during the 5th read, then a fresh burst.
        cyc(0, 1, 'h40, 20);
        idle(5);
        cyc(1, 0, 0, 0);
        chk("mid_rst_rd_en", 32'(o_rd_en), 32'd0);
        chk("mid_rst_addr", 32'(o_d_addr), 32'd0);
        rd_seen = 0;
        cyc(0, 1, 'h200, 3);
        idle(8);
        chk("post_rst_count", 32'(rd_seen), 32'd3);

        // Back-to-back: start exactly on the DRAIN->IDLE edge.
        rd_seen = 0;
        cyc(0, 1, 'h10, 2);
        idle(1 + LAT);
        cyc(0, 1, 'h20, 2);
        idle(8);
        chk("b2b_count", 32'(rd_seen), 32'd4);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            int r, s, a, n;
            r = ($urandom_range(199) == 0);
            s = ($urandom_range(15) == 0);
            a = ($urandom_range(3) == 0) ? (4096 - $urandom_range(8)) : $urandom_range(4095);
            case ($urandom_range(7))
                0: n = 0;
                1: n = 255;
                default: n = $urandom_range(40);
            endcase
            cyc(r[0], s[0], a, n);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
